// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states,
// and the 12-bit command word (op, a, b, use_acc) held in the FIFO.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD      = 3'd0;
   localparam logic [2:0] OP_SUB      = 3'd1;
   localparam logic [2:0] OP_NOTA     = 3'd2;
   localparam logic [2:0] OP_NOTB     = 3'd3;
   localparam logic [2:0] OP_AND      = 3'd4;
   localparam logic [2:0] OP_OR       = 3'd5;
   localparam logic [2:0] OP_ORRED_A  = 3'd6;
   localparam logic [2:0] OP_ANDRED_B = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       use_acc;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command stream, ALU drive/return and result stream.
// master = sequencer side, slave = environment (source, ALU, sink).
interface alu_seq_if;

   logic       Cmd_valid;
   logic       Cmd_ready;
   logic [2:0] Cmd_op;
   logic [3:0] Cmd_a;
   logic [3:0] Cmd_b;
   logic       Cmd_use_acc;
   logic [3:0] Data_A;
   logic [3:0] Data_B;
   logic [2:0] Op_code;
   logic [4:0] Alu_out;
   logic       Res_valid;
   logic       Res_ready;
   logic [4:0] Res_data;
   logic       Res_toggle;
   logic       Busy;

   modport master (
      input  Cmd_valid, Cmd_op, Cmd_a, Cmd_b, Cmd_use_acc,
      input  Alu_out, Res_ready,
      output Cmd_ready, Data_A, Data_B, Op_code,
      output Res_valid, Res_data, Res_toggle, Busy
   );

   modport slave (
      output Cmd_valid, Cmd_op, Cmd_a, Cmd_b, Cmd_use_acc,
      output Alu_out, Res_ready,
      input  Cmd_ready, Data_A, Data_B, Op_code,
      input  Res_valid, Res_data, Res_toggle, Busy
   );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO: DEPTH entries of W bits, sync active-low reset.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational 4-bit ALU: queues commands, runs them one at a time.
// Ports: Clk, Rst_n (sync, active low), bus (alu_seq_if.master).
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     Clk,
   input  logic     Rst_n,
   alu_seq_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   cmd_t          push_cmd;
   cmd_t          head_cmd;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;

   state_t     state_q, state_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] da_q, da_d;
   logic [3:0] db_q, db_d;
   logic [2:0] op_q, op_d;
   logic       rv_q, rv_d;
   logic [4:0] rd_q, rd_d;
   logic       tog_q, tog_d;

   assign push_cmd.op      = bus.Cmd_op;
   assign push_cmd.a       = bus.Cmd_a;
   assign push_cmd.b       = bus.Cmd_b;
   assign push_cmd.use_acc = bus.Cmd_use_acc;

   // Ready looks only at the registered count so it never
   // depends on a pop happening in the same cycle.
   assign bus.Cmd_ready = Rst_n & ~full;
   assign push = bus.Cmd_valid & bus.Cmd_ready;
   assign pop  = (state_q == S_IDLE) & ~empty;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Rst_n),
      .push_i  (push),
      .data_i  (push_cmd),
      .pop_i   (pop),
      .data_o  (head_cmd),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      da_d    = da_q;
      db_d    = db_q;
      op_d    = op_q;
      rv_d    = rv_q;
      rd_d    = rd_q;
      tog_d   = tog_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               // acc is always the last completed result: the FSM is serial.
               da_d    = head_cmd.use_acc ? acc_q : head_cmd.a;
               db_d    = head_cmd.b;
               op_d    = head_cmd.op;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            rd_d    = bus.Alu_out;
            acc_d   = bus.Alu_out[3:0];
            rv_d    = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.Res_ready) begin
               rv_d    = 1'b0;
               tog_d   = ~tog_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         da_q    <= '0;
         db_q    <= '0;
         op_q    <= '0;
         rv_q    <= 1'b0;
         rd_q    <= '0;
         tog_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         da_q    <= da_d;
         db_q    <= db_d;
         op_q    <= op_d;
         rv_q    <= rv_d;
         rd_q    <= rd_d;
         tog_q   <= tog_d;
      end
   end

   assign bus.Data_A     = da_q;
   assign bus.Data_B     = db_q;
   assign bus.Op_code    = op_q;
   assign bus.Res_valid  = rv_q;
   assign bus.Res_data   = rd_q;
   assign bus.Res_toggle = tog_q;
   assign bus.Busy       = (state_q != S_IDLE) | (count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU.
// Ports: none (drives clock, reset and the alu_seq_if bundle).
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   logic Clk;
   logic Rst_n;
   int   errors;
   int   checks;
   logic exp_tog;

   alu_seq_if bus ();

   alu_cmd_sequencer #(.DEPTH(4)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [4:0] alu_f(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
      logic [4:0] r;
      case (op)
         OP_ADD:     r = {1'b0, a} + {1'b0, b};
         OP_SUB:     r = {1'b0, a} - {1'b0, b};
         OP_NOTA:    r = {1'b0, ~a};
         OP_NOTB:    r = {1'b0, ~b};
         OP_AND:     r = {1'b0, a & b};
         OP_OR:      r = {1'b0, a | b};
         OP_ORRED_A: r = {4'b0, |a};
         default:    r = {4'b0, &b};
      endcase
      return r;
   endfunction

   assign bus.Alu_out = alu_f(bus.Op_code, bus.Data_A, bus.Data_B);

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cmd(input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic ua);
      bus.Cmd_valid   = 1'b1;
      bus.Cmd_op      = op;
      bus.Cmd_a       = a;
      bus.Cmd_b       = b;
      bus.Cmd_use_acc = ua;
   endtask

   // Single command into an idle, empty sequencer with Res_ready=1.
   task automatic run_cmd(input string tag, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic ua, input logic [3:0] exp_a,
                          input logic [4:0] exp_r);
      drive_cmd(op, a, b, ua);
      chk({tag, "_rdy"}, 32'(bus.Cmd_ready), 1);
      tick();
      bus.Cmd_valid = 1'b0;
      chk({tag, "_v0"}, 32'(bus.Res_valid), 0);
      tick();
      chk({tag, "_v1"}, 32'(bus.Res_valid), 0);
      chk({tag, "_dA"}, 32'(bus.Data_A), 32'(exp_a));
      tick();
      chk({tag, "_v2"}, 32'(bus.Res_valid), 1);
      chk({tag, "_res"}, 32'(bus.Res_data), 32'(exp_r));
      chk({tag, "_tg0"}, 32'(bus.Res_toggle), 32'(exp_tog));
      tick();
      exp_tog = ~exp_tog;
      chk({tag, "_tg1"}, 32'(bus.Res_toggle), 32'(exp_tog));
      chk({tag, "_v3"}, 32'(bus.Res_valid), 0);
   endtask

   task automatic drain(input string tag, input int n, input int base);
      int got;
      got = 0;
      bus.Res_ready = 1'b1;
      for (int c = 0; c < 40 && got < n; c++) begin
         if (bus.Res_valid) begin
            chk($sformatf("%s_%0d", tag, got), 32'(bus.Res_data), base + got);
            got++;
            exp_tog = ~exp_tog;
         end
         tick();
      end
      chk({tag, "_cnt"}, got, n);
      chk({tag, "_tog"}, 32'(bus.Res_toggle), 32'(exp_tog));
   endtask

   initial begin
      int   acc_n;
      logic rdy_s;
      errors  = 0;
      checks  = 0;
      exp_tog = 1'b0;
      Rst_n   = 1'b0;
      bus.Cmd_valid   = 1'b0;
      bus.Cmd_op      = '0;
      bus.Cmd_a       = '0;
      bus.Cmd_b       = '0;
      bus.Cmd_use_acc = 1'b0;
      bus.Res_ready   = 1'b0;
      tick();
      tick();
      chk("rst_rdy", 32'(bus.Cmd_ready), 0);
      chk("rst_rv", 32'(bus.Res_valid), 0);
      chk("rst_dA", 32'(bus.Data_A), 0);
      chk("rst_op", 32'(bus.Op_code), 0);
      chk("rst_busy", 32'(bus.Busy), 0);
      Rst_n = 1'b1;
      tick();
      chk("post_rdy", 32'(bus.Cmd_ready), 1);

      bus.Res_ready = 1'b1;
      run_cmd("add", OP_ADD, 4'd3, 4'd5, 1'b0, 4'd3, 5'h08);
      run_cmd("sub", OP_SUB, 4'd2, 4'd3, 1'b0, 4'd2, 5'h1F);
      run_cmd("nota", OP_NOTA, 4'hA, 4'd0, 1'b0, 4'hA, 5'h05);
      run_cmd("andb", OP_ANDRED_B, 4'd0, 4'hF, 1'b0, 4'd0, 5'h01);
      run_cmd("ch1", OP_ADD, 4'd9, 4'd9, 1'b0, 4'd9, 5'h12);
      run_cmd("ch2", OP_ADD, 4'hF, 4'd1, 1'b1, 4'd2, 5'h03);

      // Fill with Res_ready low: DEPTH+1 accepted.
      bus.Res_ready = 1'b0;
      acc_n = 0;
      for (int i = 0; i < 7; i++) begin
         drive_cmd(OP_ADD, 4'(acc_n), 4'd1, 1'b0);
         rdy_s = bus.Cmd_ready;
         tick();
         if (rdy_s) acc_n++;
      end
      bus.Cmd_valid = 1'b0;
      chk("fill_acc", acc_n, 5);
      chk("fill_rdy", 32'(bus.Cmd_ready), 0);
      chk("fill_cnt", 32'(dut.u_fifo.count_o), 4);
      for (int i = 0; i < 3; i++) begin
         chk("stall_v", 32'(bus.Res_valid), 1);
         chk("stall_d", 32'(bus.Res_data), 1);
         tick();
      end
      drain("fill", 5, 1);

      // Push and pop on the same edge with count=3.
      bus.Res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(OP_ADD, 4'(i), 4'd8, 1'b0);
         chk("sp_rdy", 32'(bus.Cmd_ready), 1);
         tick();
      end
      bus.Cmd_valid = 1'b0;
      chk("sp_cnt0", 32'(dut.u_fifo.count_o), 3);
      chk("sp_res0", 32'(bus.Res_data), 8);
      bus.Res_ready = 1'b1;
      tick();
      exp_tog = ~exp_tog;
      bus.Res_ready = 1'b0;
      chk("sp_v", 32'(bus.Res_valid), 0);
      drive_cmd(OP_ADD, 4'd4, 4'd8, 1'b0);
      chk("sp_rdy4", 32'(bus.Cmd_ready), 1);
      tick();
      bus.Cmd_valid = 1'b0;
      chk("sp_cnt1", 32'(dut.u_fifo.count_o), 3);
      chk("sp_dA", 32'(bus.Data_A), 1);
      drain("sp", 4, 9);

      // Reset while in EXEC with two queued.
      bus.Res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(OP_ADD, 4'(i), 4'd2, 1'b0);
         tick();
      end
      bus.Cmd_valid = 1'b0;
      bus.Res_ready = 1'b1;
      tick();
      bus.Res_ready = 1'b0;
      tick();
      chk("mr_cnt", 32'(dut.u_fifo.count_o), 2);
      chk("mr_dA", 32'(bus.Data_A), 1);
      chk("mr_busy", 32'(bus.Busy), 1);
      Rst_n = 1'b0;
      tick();
      chk("mr_rdy", 32'(bus.Cmd_ready), 0);
      chk("mr_dA0", 32'(bus.Data_A), 0);
      chk("mr_dB0", 32'(bus.Data_B), 0);
      chk("mr_op0", 32'(bus.Op_code), 0);
      chk("mr_rv0", 32'(bus.Res_valid), 0);
      chk("mr_rd0", 32'(bus.Res_data), 0);
      chk("mr_tg0", 32'(bus.Res_toggle), 0);
      chk("mr_busy0", 32'(bus.Busy), 0);
      exp_tog = 1'b0;
      Rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_quiet", 32'(bus.Res_valid), 0);
         chk("mr_idle", 32'(bus.Busy), 0);
      end
      bus.Res_ready = 1'b1;
      run_cmd("mr_acc", OP_ADD, 4'hF, 4'd4, 1'b1, 4'd0, 5'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
